// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, load-use interlock and bubble counter.
// Operands resolve EX > MEM > WB > register file; x0 always reads zero.
module id_ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_rs1_addr,
  input  logic [4:0]  id_rs2_addr,
  input  logic [4:0]  id_rd,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic [3:0]  id_alu_op,
  input  logic [31:0] rf_rs1_data,
  input  logic [31:0] rf_rs2_data,
  input  logic [31:0] ex_alu_result,
  input  logic        mem_valid,
  input  logic        mem_reg_write,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_result,
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        flush,
  input  logic        ex_hold,
  output logic        ex_valid,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic [4:0]  ex_rd,
  output logic [3:0]  ex_alu_op,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_imm,
  output logic [31:0] ex_rs1_data,
  output logic [31:0] ex_rs2_data,
  output logic        id_stall,
  output logic [31:0] bubble_count
);
  localparam int NUM_SRC = 2;

  logic [NUM_SRC-1:0][4:0]  src_addr;
  logic [NUM_SRC-1:0][31:0] src_rf;
  logic [NUM_SRC-1:0][31:0] src_op;
  logic                     load_use;

  assign src_addr = {id_rs2_addr, id_rs1_addr};
  assign src_rf   = {rf_rs2_data, rf_rs1_data};

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    logic ex_hit, mem_hit, wb_hit;
    // A load in EX has no result yet; its consumers are caught by the interlock.
    assign ex_hit  = ex_valid & ex_reg_write & ~ex_mem_read & (ex_rd != 5'd0) & (ex_rd == src_addr[s]);
    assign mem_hit = mem_valid & mem_reg_write & (mem_rd != 5'd0) & (mem_rd == src_addr[s]);
    assign wb_hit  = wb_en & (wb_rd != 5'd0) & (wb_rd == src_addr[s]);

    always_comb begin
      src_op[s] = src_rf[s];
      if (src_addr[s] == 5'd0) src_op[s] = '0;
      else if (ex_hit)         src_op[s] = ex_alu_result;
      else if (mem_hit)        src_op[s] = mem_result;
      else if (wb_hit)         src_op[s] = wb_data;
    end
  end

  assign load_use = id_valid & ex_valid & ex_mem_read & (ex_rd != 5'd0) &
                    ((id_uses_rs1 & (id_rs1_addr == ex_rd)) |
                     (id_uses_rs2 & (id_rs2_addr == ex_rd)));

  assign id_stall = ~flush & (ex_hold | load_use);

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_rd        <= '0;
      ex_alu_op    <= '0;
      ex_pc        <= '0;
      ex_imm       <= '0;
      ex_rs1_data  <= '0;
      ex_rs2_data  <= '0;
      bubble_count <= '0;
    end else if (flush) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
    end else if (ex_hold) begin
      // every EX register keeps its value
    end else if (load_use) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      if (bubble_count != 32'hFFFF_FFFF) bubble_count <= bubble_count + 32'd1;
    end else begin
      ex_valid     <= id_valid;
      ex_reg_write <= id_valid & id_reg_write;
      ex_mem_read  <= id_valid & id_mem_read;
      ex_rd        <= id_rd;
      ex_alu_op    <= id_alu_op;
      ex_pc        <= id_pc;
      ex_imm       <= id_imm;
      ex_rs1_data  <= src_op[0];
      ex_rs2_data  <= src_op[1];
    end
  end
endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL: clk  in  1  single rising-edge clock.
REQ-002 SHALL: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL: id_valid  in  1  instruction present in ID.
REQ-004 SHALL: id_pc, id_imm  in  32 each  ID program counter, decoded immediate.
REQ-005 SHALL: id_rs1_addr, id_rs2_addr, id_rd  in  5 each  ID register addresses.
REQ-006 SHALL: id_uses_rs1, id_uses_rs2, id_reg_write, id_mem_read  in  1 each  decode flags.
REQ-007 SHALL: id_alu_op  in  4  ALU operation code.
REQ-008 SHALL: rf_rs1_data, rf_rs2_data  in  32 each  register file combinational read data.
REQ-009 SHALL: ex_alu_result  in  32  combinational ALU result of the instruction now in EX.
REQ-010 SHALL: mem_valid, mem_reg_write  in  1; mem_rd  in  5; mem_result  in  32  MEM-stage writeback candidate.
REQ-011 SHALL: wb_en  in  1; wb_rd  in  5; wb_data  in  32  same signals driving register file en/rd/register_file_data.
REQ-012 SHALL: flush  in  1  kill instruction entering EX (taken branch/jump).
REQ-013 SHALL: ex_hold  in  1  downstream stall, freeze EX registers.
REQ-014 SHALL: ex_valid, ex_reg_write, ex_mem_read  out  1; ex_rd  out  5; ex_alu_op  out  4  registered EX control.
REQ-015 SHALL: ex_pc, ex_imm, ex_rs1_data, ex_rs2_data  out  32 each  registered EX data.
REQ-016 SHALL: id_stall  out  1  combinational; hold PC and IF/ID when 1.
REQ-017 SHALL: bubble_count  out  32  load-use bubbles inserted since reset.

Function
REQ-018 SHALL: operand select per source n (rs1, rs2), priority highest first: addr==0 -> 0; EX hit -> ex_alu_result; MEM hit -> mem_result; WB hit -> wb_data; else rf_rsn_data.
REQ-019 SHALL: EX hit = ex_valid & ex_reg_write & ~ex_mem_read & ex_rd!=0 & ex_rd==addr.
REQ-020 SHALL: MEM hit = mem_valid & mem_reg_write & mem_rd!=0 & mem_rd==addr; WB hit = wb_en & wb_rd!=0 & wb_rd==addr (covers same-edge register file write).
REQ-021 SHALL: load_use = id_valid & ex_valid & ex_mem_read & ex_rd!=0 & ((id_uses_rs1 & id_rs1_addr==ex_rd) | (id_uses_rs2 & id_rs2_addr==ex_rd)).
REQ-022 SHALL: id_stall = ~flush & (ex_hold | load_use).
REQ-023 SHALL: per rising edge, priority: rst > flush > ex_hold > load_use > advance.
REQ-024 SHALL: flush -> ex_valid<=0, ex_reg_write<=0, ex_mem_read<=0; other fields don't care; overrides ex_hold.
REQ-025 SHALL: ex_hold (no flush) -> every EX register retains its value; no bubble counted.
REQ-026 SHALL: load_use (no flush/hold) -> bubble: ex_valid<=0, ex_reg_write<=0, ex_mem_read<=0; bubble_count +1.
REQ-027 SHALL: advance -> capture all id_* fields and selected operands, ex_valid<=id_valid; id_valid=0 captures flags as 0.
REQ-028 SHALL: latency one cycle ID->EX; a load followed immediately by a dependent instruction costs exactly one bubble.
REQ-029 SHALL: bubble_count saturates at 32'hFFFF_FFFF, no wrap.
REQ-030 SHALL: operands never X: x0 reads 0 regardless of any forwarding source.

Reset
REQ-031 SHALL: rst -> ex_valid, ex_reg_write, ex_mem_read, ex_rd, ex_alu_op, ex_pc, ex_imm, ex_rs1_data, ex_rs2_data, bubble_count all 0; overrides flush/hold; mid-stall reset clears bubble and stall next cycle.

Verification
REQ-032 SHALL: EX ADD x5 (ex_alu_result=0x11), MEM x5=0x22, WB x5=0x33, ID reads rs1=x5 -> ex_rs1_data=0x11 next cycle.
REQ-033 SHALL: EX load x7, ID uses rs2=x7 -> id_stall=1, next cycle ex_valid=0, bubble_count=1; following cycle dependent captured with MEM forward mem_result=0xDEAD_BEEF.
REQ-034 SHALL: wb_en=1 wb_rd=3 wb_data=0xCAFE, rf_rs1_data=0 stale, ID rs1=x3 -> ex_rs1_data=0xCAFE.
REQ-035 SHALL: ID rs1=x0 with EX/MEM/WB all writing rd=0 value 0xFFFF -> ex_rs1_data=0.
REQ-036 SHALL: ex_hold=1 for 3 cycles with changing ID inputs -> EX outputs unchanged, id_stall=1; flush during hold -> ex_valid=0, id_stall=0.
REQ-037 SHALL: rst asserted during load-use stall -> next cycle all outputs 0, id_stall follows inputs only.
